// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared definitions for the program ROM, the fetch sequencer and the execute stage:
// instruction field positions, opcode values, register and colour codes.
package instruction_fetch_sequencer_pkg;

    // Instruction layout: [27:24] opcode, [23:0] operand, [15:0] jump target
    localparam int INSTR_WIDTH   = 28;
    localparam int OPCODE_MSB    = 27;
    localparam int OPCODE_LSB    = 24;
    localparam int OPERAND_MSB   = 23;
    localparam int OPERAND_LSB   = 0;
    localparam int TARGET_MSB    = 15;
    localparam int TARGET_LSB    = 0;
    localparam int ADDR_WIDTH    = 16;
    localparam int OPERAND_WIDTH = OPERAND_MSB - OPERAND_LSB + 1;

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_VGA = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_LED = 4'h4;

    // Register codes used by STO
    localparam logic [7:0] REG_R0 = 8'h00;
    localparam logic [7:0] REG_R1 = 8'h01;
    localparam logic [7:0] REG_R2 = 8'h02;
    localparam logic [7:0] REG_R3 = 8'h03;
    localparam logic [7:0] REG_R4 = 8'h04;

    // Colour codes used by VGA
    localparam logic [7:0] COLOUR_BLACK = 8'h00;
    localparam logic [7:0] COLOUR_RED   = 8'h01;
    localparam logic [7:0] COLOUR_GREEN = 8'h02;
    localparam logic [7:0] COLOUR_BLUE  = 8'h03;
    localparam logic [7:0] COLOUR_WHITE = 8'h07;

    // Word the ROM returns at addresses with no programmed content
    localparam logic [INSTR_WIDTH-1:0] ROM_DEFAULT = {OP_LED, 24'h000000};

    // Assemble an instruction word from opcode and operand
    function automatic logic [INSTR_WIDTH-1:0] make_instr(input logic [3:0] op,
                                                          input logic [OPERAND_WIDTH-1:0] operand);
        return {op, operand};
    endfunction

endpackage

// File: rtl/instruction_fetch_sequencer_delay_counter.sv
// Loadable down-counter timing NOP delays. tc flags the last cycle of a delay (count == 1).
module instruction_fetch_sequencer_delay_counter #(
    parameter int DELAY_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [DELAY_WIDTH-1:0] load_value,
    input  logic                   enable,
    output logic [DELAY_WIDTH-1:0] count,
    output logic                   tc
);

    // Load takes priority; otherwise decrement while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count - 1'b1;
        end
    end

    // Terminal count: the current cycle is the final delay cycle
    assign tc = (count == DELAY_WIDTH'(1));

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives the ROM address, executes NOP (timed delay)
// and JMP locally, and hands every other instruction downstream.
// Optional build macro FETCH_SINGLE_STEP_EN adds iStep: FETCH waits for an iStep pulse.
//
// Handshake: oInstValid rises with oInstruction and both hold steady until a clock
// edge where iInstReady is 1; that edge transfers the instruction and drops oInstValid.
// iInstReady while oInstValid is 0 has no effect.
module instruction_fetch_sequencer
    import instruction_fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_ADDR  = 16'd0,
    parameter int          DELAY_WIDTH = 24
) (
    input  logic        Clock,
    input  logic        Reset_n,
    output logic [15:0] oAddress,
    input  logic [27:0] iInstruction,
    output logic [27:0] oInstruction,
    output logic        oInstValid,
    input  logic        iInstReady,
    output logic        oBusy,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic        iStep,
`endif
    output logic [1:0]  oState
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        DELAY  = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    state_t                 state;
    logic [15:0]            pc;
    logic [27:0]            ir;
    logic [3:0]             ir_opcode;
    logic [23:0]            ir_operand;
    logic                   cnt_load;
    logic                   cnt_enable;
    logic                   cnt_tc;
    logic [DELAY_WIDTH-1:0] cnt_value;
    logic                   fetch_go;

    assign ir_opcode  = ir[OPCODE_MSB:OPCODE_LSB];
    assign ir_operand = ir[OPERAND_MSB:OPERAND_LSB];
    assign oAddress   = pc;
    assign oState     = state;

`ifdef FETCH_SINGLE_STEP_EN
    assign fetch_go = iStep;
`else
    assign fetch_go = 1'b1;
`endif

    // Counter is loaded while decoding a non-zero NOP and counts down through DELAY
    always_comb begin
        cnt_load   = 1'b0;
        cnt_enable = 1'b0;
        if (state == DECODE && ir_opcode == OP_NOP && ir_operand != '0) begin
            cnt_load = 1'b1;
        end
        if (state == DELAY) begin
            cnt_enable = 1'b1;
        end
    end

    instruction_fetch_sequencer_delay_counter #(
        .DELAY_WIDTH(DELAY_WIDTH)
    ) u_delay_counter (
        .clk        (Clock),
        .rst_n      (Reset_n),
        .load       (cnt_load),
        .load_value (DELAY_WIDTH'(ir_operand)),
        .enable     (cnt_enable),
        .count      (cnt_value),
        .tc         (cnt_tc)
    );

    // Main sequencer FSM with registered PC, IR and downstream outputs
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= FETCH;
            pc           <= RESET_ADDR;
            ir           <= '0;
            oInstruction <= '0;
            oInstValid   <= 1'b0;
            oBusy        <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (fetch_go) begin
                        ir    <= iInstruction;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (ir_opcode == OP_NOP) begin
                        if (ir_operand == '0) begin
                            pc    <= pc + 16'd1;
                            state <= FETCH;
                        end else begin
                            oBusy <= 1'b1;
                            state <= DELAY;
                        end
                    end else if (ir_opcode == OP_JMP) begin
                        pc    <= ir[TARGET_MSB:TARGET_LSB];
                        state <= FETCH;
                    end else begin
                        oInstruction <= ir;
                        oInstValid   <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                DELAY: begin
                    if (cnt_tc) begin
                        oBusy <= 1'b0;
                        pc    <= pc + 16'd1;
                        state <= FETCH;
                    end
                end
                ISSUE: begin
                    if (iInstReady) begin
                        oInstValid <= 1'b0;
                        pc         <= pc + 16'd1;
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer with a behavioural ROM.
module tb_instruction_fetch_sequencer;
    import instruction_fetch_sequencer_pkg::*;

    logic        Clock;
    logic        Reset_n;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic [27:0] oInstruction;
    logic        oInstValid;
    logic        iInstReady;
    logic        oBusy;
    logic [1:0]  oState;
`ifdef FETCH_SINGLE_STEP_EN
    logic        iStep;
`endif

    logic [27:0] rom [0:65535];
    int checks;
    int errors;

    instruction_fetch_sequencer #(
        .RESET_ADDR (16'd0),
        .DELAY_WIDTH(24)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .oAddress    (oAddress),
        .iInstruction(iInstruction),
        .oInstruction(oInstruction),
        .oInstValid  (oInstValid),
        .iInstReady  (iInstReady),
        .oBusy       (oBusy),
`ifdef FETCH_SINGLE_STEP_EN
        .iStep       (iStep),
`endif
        .oState      (oState)
    );

    // Clock and combinational ROM
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    assign iInstruction = rom[oAddress];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 65536; a++) rom[a] = ROM_DEFAULT;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        step();
        step();
        Reset_n = 1'b1;
    endtask

    logic [27:0] w_sto;
    logic [27:0] w_vga;
    int busy_cnt;
    int first_valid;
    int hs;

    initial begin
        checks       = 0;
        errors       = 0;
        Reset_n      = 1'b0;
        iInstReady   = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
        iStep        = 1'b0;
`endif
        w_sto = make_instr(OP_STO, {REG_R4, 16'd240});
        w_vga = make_instr(OP_VGA, {COLOUR_BLUE, 16'h1234});

`ifndef FETCH_SINGLE_STEP_EN
        // Reset state and reset in the middle of a long delay
        clear_rom();
        rom[0] = make_instr(OP_NOP, 24'd4000);
        iInstReady = 1'b1;
        do_reset();
        check("reset_addr", oAddress, 16'h0000);
        check("reset_valid", oInstValid, 1'b0);
        check("reset_busy", oBusy, 1'b0);
        check("reset_instr", oInstruction, 28'h0);
        check("reset_state", oState, 2'd0);
        repeat (100) step();
        check("delay_busy", oBusy, 1'b1);
        check("delay_state", oState, 2'd2);
        #2 Reset_n = 1'b0;
        #1;
        check("async_rst_busy", oBusy, 1'b0);
        check("async_rst_state", oState, 2'd0);
        step();
        check("mid_delay_rst_addr", oAddress, 16'h0000);
        check("mid_delay_rst_busy", oBusy, 1'b0);
        check("mid_delay_rst_valid", oInstValid, 1'b0);
        check("mid_delay_rst_state", oState, 2'd0);

        // NOP 3 then STO: 3 busy cycles, valid 7 cycles after release
        clear_rom();
        rom[0] = make_instr(OP_NOP, 24'd3);
        rom[1] = w_sto;
        iInstReady = 1'b1;
        do_reset();
        busy_cnt = 0;
        first_valid = 0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (oBusy) busy_cnt++;
            if (oInstValid && first_valid == 0) first_valid = k;
        end
        check("nop3_busy_cycles", busy_cnt, 3);
        check("nop3_first_valid", first_valid, 7);
        check("nop3_sto_word", oInstruction, w_sto);
        step();
        check("nop3_after_hs_addr", oAddress, 16'd2);
        check("nop3_after_hs_valid", oInstValid, 1'b0);

        // VGA at 6 stalled by ready low for 10 cycles
        clear_rom();
        rom[0] = make_instr(OP_JMP, 24'd6);
        rom[6] = w_vga;
        iInstReady = 1'b0;
        do_reset();
        repeat (4) step();
        check("vga_valid", oInstValid, 1'b1);
        check("vga_addr", oAddress, 16'd6);
        for (int k = 0; k < 10; k++) begin
            check("vga_stall_valid", oInstValid, 1'b1);
            check("vga_stall_word", oInstruction, w_vga);
            step();
        end
        iInstReady = 1'b1;
        step();
        check("vga_release_valid", oInstValid, 1'b0);
        check("vga_release_addr", oAddress, 16'd7);

        // JMP 0 at address 23: two cycles, no issue
        clear_rom();
        rom[0]  = make_instr(OP_JMP, 24'd23);
        rom[23] = make_instr(OP_JMP, 24'd0);
        iInstReady = 1'b1;
        do_reset();
        repeat (2) step();
        check("jmp_at_23", oAddress, 16'd23);
        step();
        check("jmp_mid_addr", oAddress, 16'd23);
        check("jmp_mid_valid", oInstValid, 1'b0);
        step();
        check("jmp_target", oAddress, 16'd0);
        check("jmp_no_valid", oInstValid, 1'b0);

        // PC wrap after issuing STO at 16'hFFFF
        clear_rom();
        rom[0]     = make_instr(OP_JMP, 24'h00FFFF);
        rom[65535] = w_sto;
        iInstReady = 1'b1;
        do_reset();
        repeat (4) step();
        check("wrap_valid", oInstValid, 1'b1);
        check("wrap_addr_ffff", oAddress, 16'hFFFF);
        step();
        check("wrap_addr_zero", oAddress, 16'h0000);

        // NOP 0 costs 2 cycles; unprogrammed address issues the ROM default
        clear_rom();
        rom[0] = make_instr(OP_NOP, 24'd0);
        rom[1] = w_sto;
        iInstReady = 1'b1;
        do_reset();
        repeat (2) step();
        check("nop0_addr", oAddress, 16'd1);
        check("nop0_busy", oBusy, 1'b0);
        repeat (2) step();
        check("nop0_sto_valid", oInstValid, 1'b1);
        check("nop0_sto_word", oInstruction, w_sto);
        repeat (3) step();
        check("default_valid", oInstValid, 1'b1);
        check("default_word", oInstruction, ROM_DEFAULT);
        check("default_addr", oAddress, 16'd2);
`else
        // Single step: one handshake per iStep pulse, nothing without it
        clear_rom();
        rom[0] = make_instr(OP_STO, {REG_R1, 16'd10});
        rom[1] = make_instr(OP_STO, {REG_R2, 16'd20});
        rom[2] = make_instr(OP_STO, {REG_R3, 16'd30});
        iInstReady = 1'b1;
        do_reset();
        check("step_reset_state", oState, 2'd0);
        hs = 0;
        repeat (20) begin
            if (oInstValid) hs++;
            step();
        end
        check("step_idle_hs", hs, 0);
        check("step_idle_addr", oAddress, 16'd0);
        check("step_idle_state", oState, 2'd0);
        for (int p = 0; p < 3; p++) begin
            iStep = 1'b1;
            step();
            iStep = 1'b0;
            hs = 0;
            repeat (19) begin
                if (oInstValid && iInstReady) begin
                    hs++;
                    check("step_word", oInstruction, rom[p]);
                end
                step();
            end
            check("step_hs_count", hs, 1);
            check("step_addr", oAddress, p + 1);
            check("step_wait_state", oState, 2'd0);
        end
        // iStep outside FETCH is ignored: pulse it while in DECODE
        iStep = 1'b1;
        step();
        check("step_decode_state", oState, 2'd1);
        step();
        iStep = 1'b0;
        repeat (10) step();
        check("step_not_queued_addr", oAddress, 16'd4);
        check("step_not_queued_state", oState, 2'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
